// File: rtl/prime_pkg.sv
// Shared FSM encoding and limits for the sequential prime detector.
// Imported by is_prime_seq and prime_rem_unit.
package prime_pkg;

  localparam int MIN_WIDTH = 3;
  localparam int MAX_WIDTH = 32;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SMALL     = 3'd1,
    ST_DIV_START = 3'd2,
    ST_DIV_WAIT  = 3'd3,
    ST_DONE      = 3'd4
  } state_e;

endpackage

// File: rtl/prime_rem_unit.sv
// Restoring remainder unit, one quotient bit per cycle; done pulses WIDTH+1 cycles after start.
// Ports: clk, rst_n, start, dividend[WIDTH], divisor[WIDTH+1], done, rem[WIDTH+1].
module prime_rem_unit
  import prime_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH:0]   divisor,
  output logic             done,
  output logic [WIDTH:0]   rem
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH:0]   r_q, r_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d;

  logic [WIDTH+1:0] shifted;
  logic [WIDTH:0]   diff;
  logic             ge;

  // The true difference is below divisor, so the low WIDTH+1 bits are exact.
  assign shifted = {r_q, q_q[WIDTH-1]};
  assign ge      = shifted >= {1'b0, divisor};
  assign diff    = shifted[WIDTH:0] - divisor;

  always_comb begin
    r_d    = r_q;
    q_d    = q_q;
    cnt_d  = cnt_q;
    done_d = 1'b0;
    if (start) begin
      r_d   = '0;
      q_d   = dividend;
      cnt_d = CW'(WIDTH);
    end else if (cnt_q != '0) begin
      r_d    = ge ? diff : shifted[WIDTH:0];
      q_d    = q_q << 1;
      cnt_d  = cnt_q - CW'(1);
      done_d = (cnt_q == CW'(1));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q    <= '0;
      q_q    <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      r_q    <= r_d;
      q_q    <= q_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign done = done_q;
  assign rem  = r_q;

endmodule

// File: rtl/is_prime_seq.sv
// Sequential trial-division prime detector with valid/ready in and out.
// Ports: clk, rst_n, in_valid/in_ready/in_value, out_valid/out_ready/out_prime, busy; out_factor if IS_PRIME_FACTOR_EN.
module is_prime_seq
  import prime_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_value,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_prime,
  output logic             busy
`ifdef IS_PRIME_FACTOR_EN
  ,
  output logic [WIDTH-1:0] out_factor
`endif
);

  if (WIDTH < MIN_WIDTH || WIDTH > MAX_WIDTH) begin : g_width_chk
    $error("is_prime_seq: WIDTH out of range");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] n_q, n_d;
  logic [WIDTH:0]   d_q, d_d;
  logic             prime_q, prime_d;
`ifdef IS_PRIME_FACTOR_EN
  logic [WIDTH-1:0] factor_q, factor_d;
`endif

  logic             rem_start;
  logic             rem_done;
  logic [WIDTH:0]   rem;
  logic [WIDTH:0]   d_plus2;
  logic [WIDTH:0]   sq_src;
  logic [2*WIDTH+1:0] sq;
  logic             sq_gt_n;

  // In DIV_WAIT the square of the next divisor is tested early, so a
  // prime exits straight to DONE instead of spending a DIV_START cycle.
  assign d_plus2 = d_q + (WIDTH+1)'(2);
  assign sq_src  = (state_q == ST_DIV_WAIT) ? d_plus2 : d_q;
  assign sq      = {{(WIDTH+1){1'b0}}, sq_src} * {{(WIDTH+1){1'b0}}, sq_src};
  assign sq_gt_n = sq > {{(WIDTH+2){1'b0}}, n_q};

  prime_rem_unit #(.WIDTH(WIDTH)) u_rem (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (rem_start),
    .dividend (n_q),
    .divisor  (d_q),
    .done     (rem_done),
    .rem      (rem)
  );

  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    d_d       = d_q;
    prime_d   = prime_q;
    rem_start = 1'b0;
`ifdef IS_PRIME_FACTOR_EN
    factor_d  = factor_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          n_d     = in_value;
          state_d = ST_SMALL;
        end
      end
      ST_SMALL: begin
        state_d = ST_DONE;
        if (n_q < WIDTH'(2)) begin
          prime_d = 1'b0;
`ifdef IS_PRIME_FACTOR_EN
          factor_d = n_q;
`endif
        end else if (n_q == WIDTH'(2) || n_q == WIDTH'(3)) begin
          prime_d = 1'b1;
`ifdef IS_PRIME_FACTOR_EN
          factor_d = n_q;
`endif
        end else if (!n_q[0]) begin
          prime_d = 1'b0;
`ifdef IS_PRIME_FACTOR_EN
          factor_d = WIDTH'(2);
`endif
        end else begin
          d_d     = (WIDTH+1)'(3);
          state_d = ST_DIV_START;
        end
      end
      ST_DIV_START: begin
        if (sq_gt_n) begin
          prime_d = 1'b1;
          state_d = ST_DONE;
`ifdef IS_PRIME_FACTOR_EN
          factor_d = n_q;
`endif
        end else begin
          rem_start = 1'b1;
          state_d   = ST_DIV_WAIT;
        end
      end
      ST_DIV_WAIT: begin
        if (rem_done) begin
          if (rem == '0) begin
            prime_d = 1'b0;
            state_d = ST_DONE;
`ifdef IS_PRIME_FACTOR_EN
            factor_d = d_q[WIDTH-1:0];
`endif
          end else if (sq_gt_n) begin
            d_d     = d_plus2;
            prime_d = 1'b1;
            state_d = ST_DONE;
`ifdef IS_PRIME_FACTOR_EN
            factor_d = n_q;
`endif
          end else begin
            d_d     = d_plus2;
            state_d = ST_DIV_START;
          end
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      n_q      <= '0;
      d_q      <= '0;
      prime_q  <= 1'b0;
`ifdef IS_PRIME_FACTOR_EN
      factor_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      n_q      <= n_d;
      d_q      <= d_d;
      prime_q  <= prime_d;
`ifdef IS_PRIME_FACTOR_EN
      factor_q <= factor_d;
`endif
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign out_prime = prime_q;
`ifdef IS_PRIME_FACTOR_EN
  assign out_factor = factor_q;
`endif

endmodule
